// File: rtl/fetch_pkg.sv
// Shared phase encodings, opcode constants and instruction payload for the fetch sequencer.
package fetch_pkg;

   localparam int unsigned PH_W  = 3;
   localparam int unsigned N_PH  = 8;
   localparam int unsigned NIB_W = 4;

   localparam logic [PH_W-1:0] PH_A1 = 3'd0;
   localparam logic [PH_W-1:0] PH_A2 = 3'd1;
   localparam logic [PH_W-1:0] PH_A3 = 3'd2;
   localparam logic [PH_W-1:0] PH_M1 = 3'd3;
   localparam logic [PH_W-1:0] PH_M2 = 3'd4;
   localparam logic [PH_W-1:0] PH_X1 = 3'd5;
   localparam logic [PH_W-1:0] PH_X2 = 3'd6;
   localparam logic [PH_W-1:0] PH_X3 = 3'd7;

   localparam logic [NIB_W-1:0] OPR_JCN = 4'h1;
   localparam logic [NIB_W-1:0] OPR_FIM = 4'h2;
   localparam logic [NIB_W-1:0] OPR_JUN = 4'h4;
   localparam logic [NIB_W-1:0] OPR_JMS = 4'h5;
   localparam logic [NIB_W-1:0] OPR_ISZ = 4'h7;

   typedef struct packed {
      logic [NIB_W-1:0]   opr;
      logic [NIB_W-1:0]   opa;
      logic [2*NIB_W-1:0] word2;
   } instr_t;

   // FIM shares opr=2 with SRC; only the even-opa form carries a second byte.
   function automatic logic is_two_word(input logic [NIB_W-1:0] opr,
                                        input logic [NIB_W-1:0] opa);
      logic res;
      res = 1'b0;
      case (opr)
         OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: res = 1'b1;
         OPR_FIM:                            res = ~opa[0];
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/phase_ctr.sv
// 8-phase machine-cycle counter; holds in X3 while stalled, resets into X3.
module phase_ctr
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   output logic [PH_W-1:0] phase_o,
   output logic [N_PH-1:0] nxt_oh_c_o
);

   logic [PH_W-1:0] ph_q;
   logic [PH_W-1:0] ph_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ph_q <= PH_X3;
      else       ph_q <= ph_d;
   end

   // Next phase plus its one-hot decode, used by the top to load registered outputs.
   always_comb begin
      ph_d       = PH_W'(ph_q + 3'd1);
      nxt_oh_c_o = '0;
      if ((ph_q == PH_X3) && stall_i) ph_d = PH_X3;
      nxt_oh_c_o[ph_d] = 1'b1;
   end

   assign phase_o = ph_q;

endmodule

// File: rtl/fetch_seq.sv
// 4004-style fetch sequencer: drives PC nibbles, captures OPR/OPA/word2, requests PC increments.
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in_i,
   input  logic               stall_i,
   input  logic [NIB_W-1:0]   d_in_i,
   output logic [NIB_W-1:0]   d_out_o,
   output logic               d_oe_o,
   output logic               sync_o,
   output logic               cm_rom_o,
   output logic [PH_W-1:0]    phase_o,
   output logic [NIB_W-1:0]   opr_o,
   output logic [NIB_W-1:0]   opa_o,
   output logic [2*NIB_W-1:0] word2_o,
   output logic               two_word_o,
   output logic               instr_valid_o,
   output logic               pc_inc_o
);

   logic [N_PH-1:0]  nxt_oh;
   logic             unused_oh;

   logic [NIB_W-1:0] d_out_q, d_out_d;
   logic             d_oe_q, d_oe_d;
   logic             sync_q, sync_d;
   logic             cm_rom_q, cm_rom_d;
   instr_t           instr_q, instr_d;
   logic             two_word_q, two_word_d;
   logic             instr_valid_q, instr_valid_d;
   logic             first_q, first_d;

   phase_ctr u_phase_ctr (
      .clk        (clk),
      .reset      (reset),
      .stall_i    (stall_i),
      .phase_o    (phase_o),
      .nxt_oh_c_o (nxt_oh)
   );

   assign unused_oh = ^{nxt_oh[PH_M1], nxt_oh[PH_X2]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_out_q       <= '0;
         d_oe_q        <= 1'b0;
         sync_q        <= 1'b1;
         cm_rom_q      <= 1'b0;
         instr_q       <= '0;
         two_word_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         first_q       <= 1'b1;
      end else begin
         d_out_q       <= d_out_d;
         d_oe_q        <= d_oe_d;
         sync_q        <= sync_d;
         cm_rom_q      <= cm_rom_d;
         instr_q       <= instr_d;
         two_word_q    <= two_word_d;
         instr_valid_q <= instr_valid_d;
         first_q       <= first_d;
      end
   end

   always_comb begin
      d_out_d       = '0;
      d_oe_d        = nxt_oh[PH_A1] | nxt_oh[PH_A2] | nxt_oh[PH_A3];
      sync_d        = nxt_oh[PH_X3];
      cm_rom_d      = nxt_oh[PH_A3] | nxt_oh[PH_M2];
      instr_d       = instr_q;
      two_word_d    = two_word_q;
      instr_valid_d = 1'b0;
      first_d       = first_q;

      // Address nibbles, low first, loaded for the phase being entered.
      if (nxt_oh[PH_A1])      d_out_d = pc_in_i[3:0];
      else if (nxt_oh[PH_A2]) d_out_d = pc_in_i[7:4];
      else if (nxt_oh[PH_A3]) d_out_d = pc_in_i[11:8];

      // Entering A1 only happens from X3, so this marks the end of the startup cycle.
      if (nxt_oh[PH_A1]) first_d = 1'b0;

      // End of M1: upper nibble of whichever word is on the bus.
      if (nxt_oh[PH_M2]) begin
         if (two_word_q) instr_d.word2[7:4] = d_in_i;
         else            instr_d.opr        = d_in_i;
      end

      // End of M2: lower nibble, then decide completion / second-word fetch.
      if (nxt_oh[PH_X1]) begin
         if (two_word_q) begin
            instr_d.word2[3:0] = d_in_i;
            two_word_d         = 1'b0;
            instr_valid_d      = 1'b1;
         end else begin
            instr_d.opa   = d_in_i;
            two_word_d    = is_two_word(instr_q.opr, d_in_i);
            instr_valid_d = ~is_two_word(instr_q.opr, d_in_i);
         end
      end
   end

   // Increment request is qualified by the live stall so it lands on the releasing clock.
   assign pc_inc_o      = nxt_oh[PH_A1] & ~first_q;

   assign d_out_o       = d_out_q;
   assign d_oe_o        = d_oe_q;
   assign sync_o        = sync_q;
   assign cm_rom_o      = cm_rom_q;
   assign opr_o         = instr_q.opr;
   assign opa_o         = instr_q.opa;
   assign word2_o       = instr_q.word2;
   assign two_word_o    = two_word_q;
   assign instr_valid_o = instr_valid_q;

endmodule
